// File: rtl/vga_pkg.sv
// Shared VGA raster constants, the timing bundle type and total/legality helpers.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480 = '{
    h_active: VGA_H_ACTIVE, h_fp: VGA_H_FP, h_sync: VGA_H_SYNC, h_bp: VGA_H_BP,
    v_active: VGA_V_ACTIVE, v_fp: VGA_V_FP, v_sync: VGA_V_SYNC, v_bp: VGA_V_BP
  };

  function automatic int unsigned h_total(input vga_timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int unsigned v_total(input vga_timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  // Every interval non-empty and both totals representable in cw bits.
  function automatic bit timing_ok(input vga_timing_t t, input int unsigned cw);
    longint unsigned span;
    if (cw < 1 || cw > 32) return 1'b0;
    if (t.h_active < 1 || t.h_fp < 1 || t.h_sync < 1 || t.h_bp < 1) return 1'b0;
    if (t.v_active < 1 || t.v_fp < 1 || t.v_sync < 1 || t.v_bp < 1) return 1'b0;
    span = longint'(1) << cw;
    return (span >= longint'(h_total(t))) && (span >= longint'(v_total(t)));
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator (master) and pixel/DAC consumers (slave).
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          enable;
  logic          pixel_ce;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          video_on;
  logic          line_start;
  logic          frame_start;
  logic          hsync;
  logic          vsync;
  logic          blank;

  modport master (
    input  enable,
    output pixel_ce, pixel_x, pixel_y, video_on, line_start, frame_start,
           hsync, vsync, blank
  );

  modport slave (
    output enable,
    input  pixel_ce, pixel_x, pixel_y, video_on, line_start, frame_start,
           hsync, vsync, blank
  );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register advancing only on shift_en; reset clears every stage.
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH:1][WIDTH-1:0] pipe;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else if (shift_en) begin
      pipe[1] <= din;
      for (int i = 2; i <= DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator on the system clock with a derived pixel
// clock-enable; sync/blank are delayed to match downstream pixel latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 2,
  parameter int CW       = 10
) (
  input  logic              clock,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);

  localparam vga_timing_t TIMING = '{
    h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
  };
  localparam int H_TOTAL = int'(h_total(TIMING));
  localparam int V_TOTAL = int'(v_total(TIMING));

  if (!timing_ok(TIMING, CW) || CLK_DIV < 1 || PIPE_DLY < 1) begin : g_cfg_err
    $fatal(1, "vga_timing_gen: illegal timing parameters");
  end

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic          ce_q;
  logic          tick;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          video_on;
  logic          hs_raw;
  logic          vs_raw;
  logic [2:0]    dly_in;
  logic [2:0]    dly_out;

  // ce_q is held (not cleared) while disabled so a tick pending at the
  // moment enable drops is delivered on re-enable rather than lost.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      ce_q    <= 1'b0;
    end else if (vga.enable) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        ce_q    <= 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
        ce_q    <= 1'b0;
      end
    end
  end

  assign tick = ce_q & vga.enable;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_raw   = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
  assign vs_raw   = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
  assign dly_in   = {hs_raw, vs_raw, video_on};

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DLY)
  ) u_dly (
    .clock    (clock),
    .rst_n    (rst_n),
    .shift_en (tick),
    .din      (dly_in),
    .dout     (dly_out)
  );

  assign vga.pixel_ce    = tick;
  assign vga.pixel_x     = h_cnt;
  assign vga.pixel_y     = v_cnt;
  assign vga.video_on    = video_on;
  assign vga.line_start  = tick && (h_cnt == '0);
  assign vga.frame_start = tick && (h_cnt == '0) && (v_cnt == '0);
  assign vga.hsync       = dly_out[2] ? HS_POL : ~HS_POL;
  assign vga.vsync       = dly_out[1] ? VS_POL : ~VS_POL;
  assign vga.blank       = dly_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three generator configurations driven in lockstep and checked against an
// arithmetic raster model plus hand-computed vectors.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct {
    int          cd;
    int          pd;
    bit          hpol;
    bit          vpol;
    vga_timing_t t;
  } cfg_t;

  typedef struct packed {
    logic       ce;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       bl;
  } obs_t;

  typedef struct {
    int n;
    bit en;
    int x;
    int y;
    bit ce;
    bit hs;
    bit vs;
    bit bl;
  } vec_t;

  logic   clock = 1'b0;
  logic   rst_n = 1'b0;
  logic   enable = 1'b0;
  longint e_cnt;
  int     errors = 0;
  int     checks = 0;
  cfg_t   ca, cb, cc;
  vec_t   tbl [9];
  obs_t   oa, ob, oc;
  bit     found;
  int     hs_lo, vs_lo, bl_hi, b_fs, b_ls, c_ce, c_fs, last_ce;

  always #5 clock = ~clock;

  // Number of enabled clock edges since reset: the whole model derives from it.
  always @(posedge clock or negedge rst_n)
    if (!rst_n) e_cnt <= 0;
    else if (enable) e_cnt <= e_cnt + 1;

  vga_timing_gen_if #(.CW(10)) ia ();
  vga_timing_gen_if #(.CW(4))  ib ();
  vga_timing_gen_if #(.CW(4))  ic ();
  assign ia.enable = enable;
  assign ib.enable = enable;
  assign ic.enable = enable;

  vga_timing_gen dut_a (.clock(clock), .rst_n(rst_n), .vga(ia));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(2), .CW(4)
  ) dut_b (.clock(clock), .rst_n(rst_n), .vga(ib));

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(3), .CW(4)
  ) dut_c (.clock(clock), .rst_n(rst_n), .vga(ic));

  assign oa = {ia.pixel_ce, ia.pixel_x, ia.pixel_y, ia.video_on, ia.line_start,
               ia.frame_start, ia.hsync, ia.vsync, ia.blank};
  assign ob = {ib.pixel_ce, 6'd0, ib.pixel_x, 6'd0, ib.pixel_y, ib.video_on,
               ib.line_start, ib.frame_start, ib.hsync, ib.vsync, ib.blank};
  assign oc = {ic.pixel_ce, 6'd0, ic.pixel_x, 6'd0, ic.pixel_y, ic.video_on,
               ic.line_start, ic.frame_start, ic.hsync, ic.vsync, ic.blank};

  // Pixel index n = ticks delivered; sync/blank show the pixel pd ticks back.
  function automatic obs_t model(input cfg_t c, input longint e, input bit en);
    obs_t   o;
    longint ht, vt, n, m, h, v, hm, vm;
    longint ha, hf, hsw, va, vf, vsw;
    ha = c.t.h_active; hf = c.t.v_fp; hf = c.t.h_fp; hsw = c.t.h_sync;
    va = c.t.v_active; vf = c.t.v_fp; vsw = c.t.v_sync;
    ht = h_total(c.t);
    vt = v_total(c.t);
    n  = (e > 0) ? (e - 1) / c.cd : 0;
    h  = n % ht;
    v  = (n / ht) % vt;
    o.ce  = en && (e > 0) && ((e % c.cd) == 0);
    o.x   = 10'(h);
    o.y   = 10'(v);
    o.von = (h < ha) && (v < va);
    o.ls  = o.ce && (h == 0);
    o.fs  = o.ls && (v == 0);
    m = n - c.pd;
    if (m < 0) begin
      o.hs = ~c.hpol;
      o.vs = ~c.vpol;
      o.bl = 1'b0;
    end else begin
      hm = m % ht;
      vm = (m / ht) % vt;
      o.hs = (hm >= ha + hf && hm < ha + hf + hsw) ? c.hpol : ~c.hpol;
      o.vs = (vm >= va + vf && vm < va + vf + vsw) ? c.vpol : ~c.vpol;
      o.bl = (hm < ha) && (vm < va);
    end
    return o;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_obs(input string d, input obs_t a, input obs_t e);
    cmp({d, ".pixel_ce"},    a.ce,  e.ce);
    cmp({d, ".pixel_x"},     a.x,   e.x);
    cmp({d, ".pixel_y"},     a.y,   e.y);
    cmp({d, ".video_on"},    a.von, e.von);
    cmp({d, ".line_start"},  a.ls,  e.ls);
    cmp({d, ".frame_start"}, a.fs,  e.fs);
    cmp({d, ".hsync"},       a.hs,  e.hs);
    cmp({d, ".vsync"},       a.vs,  e.vs);
    cmp({d, ".blank"},       a.bl,  e.bl);
  endtask

  task automatic check_all();
    cmp_obs("a", oa, model(ca, e_cnt, enable));
    cmp_obs("b", ob, model(cb, e_cnt, enable));
    cmp_obs("c", oc, model(cc, e_cnt, enable));
  endtask

  task automatic tick();
    @(negedge clock);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ca = '{cd: 2, pd: 2, hpol: 1'b0, vpol: 1'b0, t: VGA_640X480};
    cb = '{cd: 1, pd: 2, hpol: 1'b0, vpol: 1'b0, t: '{8, 2, 3, 2, 4, 1, 2, 1}};
    cc = '{cd: 3, pd: 3, hpol: 1'b1, vpol: 1'b1, t: '{8, 2, 3, 2, 4, 1, 2, 1}};
    //               n  en  x  y  ce hs vs bl   (config b, cumulative from reset)
    tbl[0] = '{ 1, 1,  0, 0, 1, 1, 1, 0};
    tbl[1] = '{ 2, 1,  2, 0, 1, 1, 1, 1};
    tbl[2] = '{10, 1, 12, 0, 1, 0, 1, 0};
    tbl[3] = '{ 3, 1,  0, 1, 1, 1, 1, 0};
    tbl[4] = '{ 4, 0,  0, 1, 0, 1, 1, 0};
    tbl[5] = '{ 1, 1,  1, 1, 1, 1, 1, 0};
    tbl[6] = '{60, 1,  1, 5, 1, 1, 1, 0};
    tbl[7] = '{15, 1,  1, 6, 1, 1, 0, 0};
    tbl[8] = '{30, 1,  1, 0, 1, 1, 1, 0};

    // Reset values and first tick after release (default config).
    rst_n = 1'b0;
    enable = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    cmp("rst a.hsync", ia.hsync, 1);
    cmp("rst a.vsync", ia.vsync, 1);
    cmp("rst a.blank", ia.blank, 0);
    cmp("rst a.pixel_x", ia.pixel_x, 0);
    cmp("rst a.pixel_y", ia.pixel_y, 0);
    cmp("rst a.video_on", ia.video_on, 1);
    cmp("rst c.hsync", ic.hsync, 0);
    check_all();
    rst_n = 1'b1;
    tick();
    cmp("a first ce early", ia.pixel_ce, 0);
    tick();
    cmp("a first ce", ia.pixel_ce, 1);
    cmp("a first frame_start", ia.frame_start, 1);

    // Table vectors on the small config.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      enable = tbl[i].en;
      repeat (tbl[i].n) tick();
      cmp($sformatf("tbl%0d b.pixel_x", i), ib.pixel_x, tbl[i].x);
      cmp($sformatf("tbl%0d b.pixel_y", i), ib.pixel_y, tbl[i].y);
      cmp($sformatf("tbl%0d b.pixel_ce", i), ib.pixel_ce, tbl[i].ce);
      cmp($sformatf("tbl%0d b.hsync", i), ib.hsync, tbl[i].hs);
      cmp($sformatf("tbl%0d b.vsync", i), ib.vsync, tbl[i].vs);
      cmp($sformatf("tbl%0d b.blank", i), ib.blank, tbl[i].bl);
    end

    // Enable gating at pixel_x == 5 on the default config.
    enable = 1'b1;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (ia.pixel_x == 10'd5) found = 1;
    end
    cmp("gate reach x=5", found, 1);
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      cmp("gate hold x", ia.pixel_x, 5);
      cmp("gate no ce", ia.pixel_ce, 0);
      cmp("gate hsync held", ia.hsync, 1);
      cmp("gate blank held", ia.blank, 1);
    end
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      tick();
      if (ia.pixel_ce) found = 1;
    end
    cmp("regate ce seen", found, 1);
    cmp("regate x at ce", ia.pixel_x, 5);
    tick();
    cmp("regate x next", ia.pixel_x, 6);

    // Randomised enable with rare reset pulses.
    for (int i = 0; i < 2500; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    // Async reset mid-line, asserted between clock edges.
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (ia.pixel_x == 10'd300) found = 1;
    end
    cmp("reach x=300", found, 1);
    @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    cmp("async a.pixel_x", ia.pixel_x, 0);
    cmp("async a.hsync", ia.hsync, 1);
    cmp("async a.blank", ia.blank, 0);
    cmp("async c.vsync", ic.vsync, 0);
    check_all();
    @(negedge clock);
    rst_n = 1'b1;

    // Frame-level timing over 360 clocks (3 frames of b, 1 frame of c).
    repeat (6) tick();
    hs_lo = 0; vs_lo = 0; bl_hi = 0; b_fs = 0; b_ls = 0;
    c_ce = 0; c_fs = 0; last_ce = -1;
    for (int i = 0; i < 360; i++) begin
      tick();
      if (!ib.hsync) hs_lo++;
      if (!ib.vsync) vs_lo++;
      if (ib.blank) bl_hi++;
      if (ib.frame_start) b_fs++;
      if (ib.line_start) b_ls++;
      if (ic.frame_start) c_fs++;
      if (ic.pixel_ce) begin
        if (last_ce >= 0) cmp("c ce period", i - last_ce, 3);
        last_ce = i;
        c_ce++;
      end
    end
    cmp("b hsync low clocks", hs_lo, 72);
    cmp("b vsync low clocks", vs_lo, 90);
    cmp("b blank high clocks", bl_hi, 96);
    cmp("b frame_start count", b_fs, 3);
    cmp("b line_start count", b_ls, 24);
    cmp("c pixel_ce count", c_ce, 120);
    cmp("c frame_start count", c_fs, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
